// File: rtl/palette_pkg.sv
// Shared defaults and FSM state type for the palette RAM arbiter.
package palette_pkg;
  localparam int PAL_ADDR_W = 13;
  localparam int PAL_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_DATA  = 3'd2,
    ACK      = 3'd3,
    WAIT_BUF = 3'd4
  } pal_arb_state_t;
endpackage

// File: rtl/palette_arbiter.sv
// Palette RAM arbiter: video owns every ce_pixel slot, the CPU uses the rest.
// CPU writes are posted into a one-entry buffer and drained in a later CPU
// slot. Any new request waits for the buffer to empty, so a read that follows
// a write always sees the new data.
module palette_arbiter
  import palette_pkg::*;
#(
  parameter int ADDR_W = PAL_ADDR_W,
  parameter int DATA_W = PAL_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_pixel,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  output logic [DATA_W-1:0] cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we_l,
  output logic              ram_we_h
);

  pal_arb_state_t    r_state, w_state_nxt;
  logic              r_pend;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_data;
  logic [1:0]        r_buf_be;
  logic              r_vid_slot_d;
  logic [DATA_W-1:0] r_vid_data;
  logic [DATA_W-1:0] r_cpu_dout;

  logic w_drain;    // CPU slot spent emptying the write buffer
  logic w_issue;    // CPU slot spent presenting the read address
  logic w_eval;     // FSM is free to accept a new request this cycle
  logic w_capture;  // posted write accepted into the buffer

  // The buffer has priority over a read issue so reads observe earlier writes.
  assign w_drain = !ce_pixel && r_pend;
  assign w_issue = !ce_pixel && !r_pend && (r_state == RD_ISSUE);
  // WAIT_BUF behaves like IDLE once the buffer has drained.
  assign w_eval  = (r_state == IDLE) || (r_state == WAIT_BUF && !r_pend);

  // Next-state and buffer-capture decode.
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      IDLE, WAIT_BUF: ;
      RD_ISSUE:       if (w_issue) w_state_nxt = RD_DATA;
      RD_DATA:        w_state_nxt = ACK;
      ACK:            if (!cpu_req) w_state_nxt = IDLE;
      default:        w_state_nxt = IDLE;
    endcase
    if (w_eval) begin
      if (!cpu_req) begin
        w_state_nxt = IDLE;
      end else if (r_pend) begin
        w_state_nxt = WAIT_BUF;
      end else if (cpu_we) begin
        w_state_nxt = ACK;
        w_capture   = 1'b1;
      end else begin
        w_state_nxt = RD_ISSUE;
      end
    end
  end

  // Slot mux: video slot, else drain, else read issue, else idle on video addr.
  // Strobes are held off during reset so a pending write can never land.
  always_comb begin
    ram_addr = vid_addr;
    ram_we_l = 1'b0;
    ram_we_h = 1'b0;
    if (!reset) begin
      if (w_drain) begin
        ram_addr = r_buf_addr;
        ram_we_h = r_buf_be[1];
        ram_we_l = r_buf_be[0];
      end else if (w_issue) begin
        ram_addr = cpu_addr;
      end
    end
  end

  assign ram_din  = r_buf_data;
  assign cpu_ack  = (r_state == ACK);
  assign vid_data = r_vid_data;
  assign cpu_dout = r_cpu_dout;

  // FSM state and write-buffer occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture)    r_pend <= 1'b1;
      else if (w_drain) r_pend <= 1'b0;
    end
  end

  // Posted-write buffer contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_addr <= '0;
      r_buf_data <= '0;
      r_buf_be   <= '0;
    end else if (w_capture) begin
      r_buf_addr <= cpu_addr;
      r_buf_data <= cpu_din;
      r_buf_be   <= cpu_be;
    end
  end

  // Video return path: RAM data arrives the cycle after the video slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vid_slot_d <= 1'b0;
      r_vid_data   <= '0;
    end else begin
      r_vid_slot_d <= ce_pixel;
      if (r_vid_slot_d) r_vid_data <= ram_dout;
    end
  end

  // CPU read data, captured in RD_DATA and held through ACK.
  always_ff @(posedge clk) begin
    if (reset)                   r_cpu_dout <= '0;
    else if (r_state == RD_DATA) r_cpu_dout <= ram_dout;
  end

endmodule
